// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, operation classes, immediate formats.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_IMM     = 4'd7,
        OP_REG     = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_ILLEGAL = 4'd11
    } op_class_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // The 7-bit compare includes instr[1:0]=2'b11, so compressed encodings fall to ILLEGAL.
    function automatic op_class_e decode_op(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI:    decode_op = OP_LUI;
            OPC_AUIPC:  decode_op = OP_AUIPC;
            OPC_JAL:    decode_op = OP_JAL;
            OPC_JALR:   decode_op = OP_JALR;
            OPC_BRANCH: decode_op = OP_BRANCH;
            OPC_LOAD:   decode_op = OP_LOAD;
            OPC_STORE:  decode_op = OP_STORE;
            OPC_IMM:    decode_op = OP_IMM;
            OPC_REG:    decode_op = OP_REG;
            OPC_FENCE:  decode_op = OP_FENCE;
            OPC_SYSTEM: decode_op = OP_SYSTEM;
            default:    decode_op = OP_ILLEGAL;
        endcase
    endfunction

    function automatic imm_fmt_e imm_fmt(input op_class_e op);
        case (op)
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: imm_fmt = IMM_I;
            OP_STORE:                            imm_fmt = IMM_S;
            OP_BRANCH:                           imm_fmt = IMM_B;
            OP_LUI, OP_AUIPC:                    imm_fmt = IMM_U;
            OP_JAL:                              imm_fmt = IMM_J;
            default:                             imm_fmt = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; every format sign-extends from instr[31].
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_fmt(decode_op(instr[6:0]));

    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'd0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand read with writeback bypass, load-use interlock, ID/EX register.
module decode_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_rd_we,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_data,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd_addr,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rd_addr,
    output logic [3:0]  id_op,
    output logic [3:0]  id_funct,
    output logic        id_illegal
);

    op_class_e   op;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_used;
    logic        rs2_used;
    logic        hazard;
    logic        stage_free;
    logic        accept;
    logic        funct_hi;
    logic        no_rd;

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];
    assign op       = decode_op(if_instr[6:0]);

    imm_gen u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // Writeback to x0 is never forwarded; x0 always reads as zero.
    always_comb begin
        rs1_val = rs1_data;
        if (rs1_addr == 5'd0)
            rs1_val = 32'd0;
        else if (wb_rd_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs1_addr))
            rs1_val = wb_rd_data;

        rs2_val = rs2_data;
        if (rs2_addr == 5'd0)
            rs2_val = 32'd0;
        else if (wb_rd_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs2_addr))
            rs2_val = wb_rd_data;
    end

    assign rs1_used = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    assign rs2_used = (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_REG);

    assign hazard = if_valid && ex_load && (ex_rd_addr != 5'd0) &&
                    ((rs1_used && (ex_rd_addr == rs1_addr)) ||
                     (rs2_used && (ex_rd_addr == rs2_addr)));

    assign stage_free = !id_valid || ex_ready;
    assign if_ready   = stage_free && !hazard;
    assign accept     = if_valid && if_ready;

    // funct7[5] only distinguishes ops for REG and for the IMM shift-right group.
    assign funct_hi = ((op == OP_REG) || ((op == OP_IMM) && (if_instr[14:12] == 3'b101)))
                      ? if_instr[30] : 1'b0;
    assign no_rd    = (op == OP_BRANCH) || (op == OP_STORE) ||
                      (op == OP_FENCE)  || (op == OP_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_pc      <= 32'd0;
            id_rs1_val <= 32'd0;
            id_rs2_val <= 32'd0;
            id_imm     <= 32'd0;
            id_rd_addr <= 5'd0;
            id_op      <= 4'd0;
            id_funct   <= 4'd0;
            id_illegal <= 1'b0;
        end else begin
            if (flush)
                id_valid <= 1'b0;
            else if (stage_free)
                id_valid <= if_valid && !hazard;

            if (accept) begin
                id_pc      <= if_pc;
                id_rs1_val <= rs1_val;
                id_rs2_val <= rs2_val;
                id_imm     <= imm;
                id_rd_addr <= no_rd ? 5'd0 : if_instr[11:7];
                id_op      <= op;
                id_funct   <= {funct_hi, if_instr[14:12]};
                id_illegal <= (op == OP_ILLEGAL);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_rd_we;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        ex_load;
    logic [4:0]  ex_rd_addr;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rd_addr;
    logic [3:0]  id_op;
    logic [3:0]  id_funct;
    logic        id_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_rd_we   (wb_rd_we),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .ex_load    (ex_load),
        .ex_rd_addr (ex_rd_addr),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .id_rd_addr (id_rd_addr),
        .id_op      (id_op),
        .id_funct   (id_funct),
        .id_illegal (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        rs1_data = '0; rs2_data = '0; wb_rd_we = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
        ex_load = 1'b0; ex_rd_addr = '0; flush = 1'b0; ex_ready = 1'b1;

        #1;
        chk_val("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk_val("rst_id_pc", id_pc, 32'd0);
        chk_val("rst_id_op", {28'd0, id_op}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk_val("idle_if_ready", {31'd0, if_ready}, 32'd1);

        // ADDI x1,x2,-5 accepted on the first edge after reset release
        present(32'h100, 32'hFFB10093);
        rs1_data = 32'h10;
        #1;
        chk_val("addi_rs1_addr", {27'd0, rs1_addr}, 32'd2);
        chk_val("addi_rs2_addr", {27'd0, rs2_addr}, 32'd27);
        tick();
        chk_val("addi_valid", {31'd0, id_valid}, 32'd1);
        chk_val("addi_op", {28'd0, id_op}, 32'd7);
        chk_val("addi_imm", id_imm, 32'hFFFFFFFB);
        chk_val("addi_rs1", id_rs1_val, 32'h10);
        chk_val("addi_rd", {27'd0, id_rd_addr}, 32'd1);
        chk_val("addi_funct", {28'd0, id_funct}, 32'd0);
        chk_val("addi_pc", id_pc, 32'h100);

        // writeback bypass on rs1
        wb_rd_we = 1'b1; wb_rd_addr = 5'd2; wb_rd_data = 32'hDEAD0000;
        tick();
        chk_val("fwd_rs1", id_rs1_val, 32'hDEAD0000);

        // rs1=x0 with wb to x0: operand is zero regardless of data
        present(32'h104, 32'hFFB00093);
        rs1_data = 32'h55; wb_rd_addr = 5'd0;
        tick();
        chk_val("x0_rs1", id_rs1_val, 32'd0);

        // ADD x3,x2,x4: bypass on rs2 only, rs1 from regfile
        present(32'h108, 32'h004101B3);
        rs1_data = 32'h1111; rs2_data = 32'h2222;
        wb_rd_addr = 5'd4; wb_rd_data = 32'hCAFE0004;
        tick();
        chk_val("add_rs1", id_rs1_val, 32'h1111);
        chk_val("fwd_rs2", id_rs2_val, 32'hCAFE0004);
        wb_rd_we = 1'b0;

        // load-use on rs1 of ADD inserts exactly one bubble
        present(32'h10C, 32'h004101B3);
        ex_load = 1'b1; ex_rd_addr = 5'd2;
        #1;
        chk_val("hz_if_ready", {31'd0, if_ready}, 32'd0);
        tick();
        chk_val("hz_bubble", {31'd0, id_valid}, 32'd0);
        ex_load = 1'b0;
        #1;
        chk_val("hz_clear_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk_val("hz_accept_valid", {31'd0, id_valid}, 32'd1);
        chk_val("hz_accept_op", {28'd0, id_op}, 32'd8);
        chk_val("hz_accept_rd", {27'd0, id_rd_addr}, 32'd3);
        chk_val("hz_accept_pc", id_pc, 32'h10C);

        // load into rs2 slot of ADDI is not a hazard (rs2 unused); load to x0 never is
        present(32'h110, 32'hFFB10093);
        ex_load = 1'b1; ex_rd_addr = 5'd27;
        #1;
        chk_val("hz_rs2_unused", {31'd0, if_ready}, 32'd1);
        present(32'h110, 32'hFFB00093);
        ex_rd_addr = 5'd0;
        #1;
        chk_val("hz_rd_x0", {31'd0, if_ready}, 32'd1);
        ex_load = 1'b0;

        // SRAI x1,x2,3 carries funct7[5]
        present(32'h114, 32'h40315093);
        tick();
        chk_val("srai_funct", {28'd0, id_funct}, 32'hD);
        chk_val("srai_imm", id_imm, 32'h403);

        // LUI, JAL, SW, illegal
        present(32'h118, 32'h123450B7);
        tick();
        chk_val("lui_imm", id_imm, 32'h12345000);
        chk_val("lui_op", {28'd0, id_op}, 32'd0);
        present(32'h11C, 32'h008000EF);
        tick();
        chk_val("jal_imm", id_imm, 32'd8);
        chk_val("jal_rd", {27'd0, id_rd_addr}, 32'd1);
        present(32'h120, 32'h0020A223);
        tick();
        chk_val("sw_imm", id_imm, 32'd4);
        chk_val("sw_rd", {27'd0, id_rd_addr}, 32'd0);
        chk_val("sw_op", {28'd0, id_op}, 32'd6);
        present(32'h124, 32'h00000000);
        tick();
        chk_val("ill_flag", {31'd0, id_illegal}, 32'd1);
        chk_val("ill_op", {28'd0, id_op}, 32'd11);
        chk_val("ill_imm", id_imm, 32'd0);

        // BEQ x1,x2,-8 then stall three cycles with a new instruction waiting
        present(32'h200, 32'hFE208CE3);
        rs1_data = 32'h11; rs2_data = 32'h22;
        tick();
        chk_val("beq_imm", id_imm, 32'hFFFFFFF8);
        chk_val("beq_rd", {27'd0, id_rd_addr}, 32'd0);
        chk_val("beq_op", {28'd0, id_op}, 32'd4);
        chk_val("beq_illegal", {31'd0, id_illegal}, 32'd0);
        present(32'h204, 32'hFFB10093);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_val("stall_if_ready", {31'd0, if_ready}, 32'd0);
            tick();
            chk_val("stall_valid", {31'd0, id_valid}, 32'd1);
            chk_val("stall_pc", id_pc, 32'h200);
            chk_val("stall_imm", id_imm, 32'hFFFFFFF8);
            chk_val("stall_rs2", id_rs2_val, 32'h22);
        end
        ex_ready = 1'b1;
        tick();
        chk_val("unstall_pc", id_pc, 32'h204);

        // flush discards whatever is accepted in the same cycle
        flush = 1'b1;
        #1;
        chk_val("flush_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk_val("flush_valid", {31'd0, id_valid}, 32'd0);
        flush = 1'b0;
        tick();
        chk_val("post_flush_valid", {31'd0, id_valid}, 32'd1);

        // asynchronous reset in the middle of a stall
        ex_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async_rst_valid", {31'd0, id_valid}, 32'd0);
        chk_val("async_rst_pc", id_pc, 32'd0);
        chk_val("async_rst_imm", id_imm, 32'd0);
        tick();
        rst_n = 1'b1;
        present(32'h300, 32'hFFB10093);
        tick();
        chk_val("rst_first_accept", {31'd0, id_valid}, 32'd1);
        chk_val("rst_first_pc", id_pc, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 if_valid  in  1  fetch presents an instruction.
REQ-004 if_ready  out  1  decode accepts the instruction this cycle.
REQ-005 if_pc  in  32  PC of presented instruction.
REQ-006 if_instr  in  32  presented instruction word.
REQ-007 rs1_addr  out  5  register-file read address, = if_instr[19:15].
REQ-008 rs2_addr  out  5  register-file read address, = if_instr[24:20].
REQ-009 rs1_data  in  32  register-file read data, combinational, same cycle.
REQ-010 rs2_data  in  32  register-file read data, combinational, same cycle.
REQ-011 wb_rd_we  in  1  writeback write enable this cycle.
REQ-012 wb_rd_addr  in  5  writeback destination.
REQ-013 wb_rd_data  in  32  writeback data.
REQ-014 ex_load  in  1  instruction now in EX is a valid load.
REQ-015 ex_rd_addr  in  5  destination of that EX instruction.
REQ-016 flush  in  1  discard ID/EX contents (taken branch/jump).
REQ-017 ex_ready  in  1  EX accepts the ID/EX register this cycle.
REQ-018 id_valid  out  1  ID/EX register holds a valid instruction.
REQ-019 id_pc  out  32  captured PC.
REQ-020 id_rs1_val  out  32  captured rs1 operand.
REQ-021 id_rs2_val  out  32  captured rs2 operand.
REQ-022 id_imm  out  32  sign-extended immediate.
REQ-023 id_rd_addr  out  5  destination, 0 when the instruction writes no register.
REQ-024 id_op  out  4  operation class (package enum).
REQ-025 id_funct  out  4  {funct7 bit 5, funct3}.
REQ-026 id_illegal  out  1  unrecognised opcode.

Function
REQ-027 Read addresses SHALL be driven from if_instr bits combinationally, regardless of if_valid.
REQ-028 Operand select per port: address 0 gives 0; else a match with wb_rd_we=1 and wb_rd_addr!=0 gives wb_rd_data; else register-file data.
REQ-029 hazard = if_valid & ex_load & ex_rd_addr!=0 & (ex_rd_addr matches a used source); rs1 is used by all classes except LUI/AUIPC/JAL; rs2 by BRANCH/STORE/REG.
REQ-030 if_ready = (!id_valid | ex_ready) & !hazard, combinational; it does not depend on flush.
REQ-031 id_valid next-state priority:
- flush -> 0;
- else (!id_valid | ex_ready) -> if_valid & !hazard;
- else hold.
A hazard therefore inserts exactly one bubble.
REQ-032 Payload outputs SHALL load only when if_valid & if_ready; otherwise they hold, staying stable while id_valid & !ex_ready. Latency is one cycle.
REQ-033 Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, IMM, REG, FENCE, SYSTEM, ILLEGAL.
- instr[1:0]!=2'b11 or an unknown opcode -> ILLEGAL with id_illegal=1.
REQ-034 id_imm formats:
- I for JALR/LOAD/IMM/SYSTEM; S; B; U; J.
- All sign-extended from instr[31]; REG/FENCE/ILLEGAL give 0.
REQ-035 id_funct[3] = instr[30] for REG, and for IMM only when funct3=3'b101; otherwise 0.
REQ-036 id_rd_addr = instr[11:7], forced 0 for BRANCH/STORE/FENCE/ILLEGAL.
REQ-037 An instruction accepted in a flush cycle SHALL be discarded (id_valid=0 next cycle).

Reset
REQ-038 rst_n low SHALL immediately force id_valid=0 and every id_* payload output to 0, including mid-stall.
REQ-039 After rst_n deasserts, the first accept SHALL occur on the next edge with if_valid=1.

Structure
REQ-040 Opcode constants, the 4-bit op-class enum and the immediate-format encodings SHALL live in the shared package rv32i_pkg.
REQ-041 Immediate generation SHALL be a sub-module imm_gen (instr in, imm out, combinational); the pipeline register and hazard logic stay in decode_stage.

Verification
REQ-042 ADDI x1,x2,-5 (0xFFB10093), rs1_data=0x10 -> next cycle: id_valid=1, id_op=IMM, id_imm=0xFFFFFFFB, id_rs1_val=0x10, id_rd_addr=1, id_funct=0.
REQ-043 Same instruction with wb_rd_we=1, wb_rd_addr=2, wb_rd_data=0xDEAD0000 -> id_rs1_val=0xDEAD0000. With wb_rd_addr=0 and rs1 forced to x0 -> id_rs1_val=0.
REQ-044 ex_load=1, ex_rd_addr=2, ADD x3,x2,x4 presented -> if_ready=0 and one bubble (id_valid=0). Next cycle with ex_load=0 -> accepted.
REQ-045 BEQ x1,x2,-8 (0xFE208CE3) -> id_imm=0xFFFFFFF8, id_rd_addr=0, id_op=BRANCH. ex_ready=0 for 3 cycles -> all id_* stable and if_ready=0.
REQ-046 flush with id_valid=1 and if_valid=1 -> id_valid=0 next cycle. rst_n pulsed low during a stall -> id_valid=0 without a clock edge.
